pipe_stage_hs: RTL



---
 rtl/pipe_stage_hs.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_hs.sv
// Chained valid/ready pipeline register with per-stage skid buffer, flush, and zeroed ctrl on bubbles.
// Optional cycle counter of output back-pressure enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_hs #(
   parameter int DATA_W     = 96,
   parameter int CTRL_W     = 16,
   parameter int NUM_STAGES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   // state | meaning
   // EMPTY | main invalid, skid invalid
   // ONE   | main valid, skid invalid
   // FULL  | main and skid valid, stage not ready
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   logic [NUM_STAGES-1:0] stg_v;
   logic [NUM_STAGES-1:0] stg_rdy;
   logic [DATA_W-1:0]     stg_d [NUM_STAGES];
   logic [CTRL_W-1:0]     stg_c [NUM_STAGES];

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      state_t            state_q, state_nx;
      logic              rdy_q;
      logic [DATA_W-1:0] main_d, skid_d, up_d;
      logic [CTRL_W-1:0] main_c, skid_c, up_c;
      logic              up_v, dn_rdy, accept, take;
      logic              ld_main_up, ld_main_skid, ld_skid, clr_main, clr_skid;

      if (s == 0) begin : g_head
         assign up_v = in_valid;
         assign up_d = in_data;
         assign up_c = in_ctrl;
      end else begin : g_link
         assign up_v = stg_v[s-1];
         assign up_d = stg_d[s-1];
         assign up_c = stg_c[s-1];
      end

      if (s == NUM_STAGES-1) begin : g_tail
         assign dn_rdy = out_ready;
      end else begin : g_mid
         assign dn_rdy = stg_rdy[s+1];
      end

      assign accept = up_v && rdy_q;
      assign take   = (state_q != EMPTY) && dn_rdy;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            main_d  <= '0;
            main_c  <= '0;
            skid_d  <= '0;
            skid_c  <= '0;
         end else if (flush) begin
            // data is deliberately kept; only validity and ctrl are killed
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            main_c  <= '0;
            skid_c  <= '0;
         end else begin
            state_q <= state_nx;
            rdy_q   <= (state_nx != FULL);
            if (ld_main_up) begin
               main_d <= up_d;
               main_c <= up_c;
            end else if (ld_main_skid) begin
               main_d <= skid_d;
               main_c <= skid_c;
            end else if (clr_main) begin
               main_c <= '0;
            end
            if (ld_skid) begin
               skid_d <= up_d;
               skid_c <= up_c;
            end else if (clr_skid) begin
               skid_c <= '0;
            end
         end
      end

      always_comb begin
         state_nx = state_q;
         case (state_q)
            EMPTY:   if (accept) state_nx = ONE;
            ONE: begin
               if (accept && !take)      state_nx = FULL;
               else if (!accept && take) state_nx = EMPTY;
            end
            FULL:    if (take) state_nx = ONE;
            default: state_nx = EMPTY;
         endcase
      end

      always_comb begin
         ld_main_up   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
         clr_main     = 1'b0;
         clr_skid     = 1'b0;
         case (state_q)
            EMPTY: ld_main_up = accept;
            ONE: begin
               if (accept && take) ld_main_up = 1'b1;
               else if (accept)    ld_skid    = 1'b1;
               else if (take)      clr_main   = 1'b1;
            end
            FULL: begin
               ld_main_skid = take;
               clr_skid     = take;
            end
            default: ;
         endcase
      end

      assign stg_v[s]   = (state_q != EMPTY);
      assign stg_rdy[s] = rdy_q;
      assign stg_d[s]   = main_d;
      assign stg_c[s]   = main_c;
   end

   assign in_ready  = stg_rdy[0];
   assign out_valid = stg_v[NUM_STAGES-1];
   assign out_data  = stg_d[NUM_STAGES-1];
   assign out_ctrl  = stg_c[NUM_STAGES-1];

`ifdef PIPE_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule
